// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding, ASCII constants and error codes
// for the UART command-line parser.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARG     = 2'd1,
      DISCARD = 2'd2,
      EXEC    = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_9   = 8'h39;
   localparam logic [7:0] ASCII_A   = 8'h41;
   localparam logic [7:0] ASCII_Z   = 8'h5A;
   localparam logic [7:0] ASCII_LA  = 8'h61;
   localparam logic [7:0] ASCII_LZ  = 8'h7A;

   localparam logic [1:0] ERR_BADCHAR = 2'd0;
   localparam logic [1:0] ERR_OVF     = 2'd1;
   localparam logic [1:0] ERR_TMO     = 2'd2;

   // Lower-case letters map onto upper case; every other byte is unchanged.
   function automatic logic [7:0] fold_case(input logic [7:0] b);
      if (b >= ASCII_LA && b <= ASCII_LZ) return b - 8'h20;
      return b;
   endfunction

endpackage

// File: rtl/uart_cmd_dec_acc.sv
// uart_cmd_dec_acc: decimal argument accumulator (value = value*10 + digit).
// Overflow is sticky until clr; once set, the value stops updating so it is
// never presented wrapped.
module uart_cmd_dec_acc
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ARG_W      = 16,
   parameter int unsigned MAX_DIGITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [3:0]       digit,
   output logic [ARG_W-1:0] value,
   output logic             ovf
);

   localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 2);
   localparam logic [ARG_W+3:0] MAX_ARG = {4'b0000, {ARG_W{1'b1}}};

   logic [ARG_W-1:0]  r_value;
   logic              r_ovf;
   logic [NDIG_W-1:0] r_ndig;
   logic [ARG_W+3:0]  w_mac;
   logic [NDIG_W-1:0] w_ndig_next;
   logic              w_over;

   // Wide multiply-accumulate, range-checked before truncation.
   always_comb begin
      w_mac       = ({4'b0000, r_value} << 3) + ({4'b0000, r_value} << 1)
                  + {{ARG_W{1'b0}}, digit};
      w_ndig_next = r_ndig + NDIG_W'(1);
      w_over      = (w_mac > MAX_ARG) || (w_ndig_next > NDIG_W'(MAX_DIGITS));
   end

   // Accumulator, digit count and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value <= '0;
         r_ovf   <= 1'b0;
         r_ndig  <= '0;
      end else if (clr) begin
         r_value <= '0;
         r_ovf   <= 1'b0;
         r_ndig  <= '0;
      end else if (en && !r_ovf) begin
         if (w_over) begin
            r_ovf <= 1'b1;
         end else begin
            r_value <= w_mac[ARG_W-1:0];
            r_ndig  <= w_ndig_next;
         end
      end
   end

   assign value = r_value;
   assign ovf   = r_ovf;

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses "<letter>[digits]<CR|LF>" lines popped from a
// show-ahead RX FIFO into one command (code + decimal argument) or an error.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ARG_W       = 16,
   parameter int unsigned MAX_DIGITS  = 5
`ifdef CMD_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [7:0]       fifo_data,
   output logic             fifo_pop,
   output logic             cmd_valid,
   output logic [7:0]       cmd_code,
   output logic [ARG_W-1:0] cmd_arg,
   output logic             cmd_has_arg,
   output logic             cmd_err,
   output logic [1:0]       err_code
);

   state_t           r_state, w_state_next;
   logic [7:0]       r_letter;
   logic             r_has_digit;
   logic [7:0]       r_cmd_code;
   logic [ARG_W-1:0] r_cmd_arg;
   logic             r_cmd_has_arg;
   logic             r_cmd_err;
   logic [1:0]       r_err_code;

   logic [7:0]       w_byte;
   logic             w_is_letter, w_is_digit, w_is_term;
   logic             w_pop, w_tmo;
   logic             w_acc_clr, w_acc_en, w_latch;
   logic             w_err;
   logic [1:0]       w_err_code;
   logic [ARG_W-1:0] w_acc_value;
   logic             w_acc_ovf;

   assign w_byte      = fold_case(fifo_data);
   assign w_is_letter = (w_byte >= ASCII_A) && (w_byte <= ASCII_Z);
   assign w_is_digit  = (w_byte >= ASCII_0) && (w_byte <= ASCII_9);
   assign w_is_term   = (w_byte == ASCII_CR) || (w_byte == ASCII_LF);
   // Gated by rst so the pop output also reads 0 while reset is held.
   assign w_pop       = rst && !fifo_empty && (r_state != EXEC);

   uart_cmd_dec_acc #(
      .ARG_W      (ARG_W),
      .MAX_DIGITS (MAX_DIGITS)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_acc_clr),
      .en    (w_acc_en),
      .digit (w_byte[3:0]),
      .value (w_acc_value),
      .ovf   (w_acc_ovf)
   );

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_in_line;

   assign w_in_line = (r_state == ARG) || (r_state == DISCARD);
   assign w_tmo     = w_in_line && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   // Inter-byte idle counter; restarts on every pop and outside a line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     r_tmo_cnt <= '0;
      else if (w_pop || !w_in_line) r_tmo_cnt <= '0;
      else                          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
   end
`else
   assign w_tmo = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state decode; a popped byte always takes priority over a timeout.
   always_comb begin
      w_state_next = r_state;
      w_acc_clr    = 1'b0;
      w_acc_en     = 1'b0;
      w_latch      = 1'b0;
      w_err        = 1'b0;
      w_err_code   = ERR_BADCHAR;
      unique case (r_state)
         IDLE: begin
            if (w_pop) begin
               if (w_is_letter) begin
                  w_latch      = 1'b1;
                  w_acc_clr    = 1'b1;
                  w_state_next = ARG;
               end else if (!w_is_term) begin
                  w_state_next = DISCARD;
               end
            end
         end
         ARG: begin
            if (w_pop) begin
               if (w_is_digit) begin
                  w_acc_en = 1'b1;
               end else if (w_is_term) begin
                  if (w_acc_ovf) begin
                     w_err        = 1'b1;
                     w_err_code   = ERR_OVF;
                     w_state_next = IDLE;
                  end else begin
                     w_state_next = EXEC;
                  end
               end else begin
                  w_state_next = DISCARD;
               end
            end else if (w_tmo) begin
               w_err        = 1'b1;
               w_err_code   = ERR_TMO;
               w_state_next = IDLE;
            end
         end
         DISCARD: begin
            if (w_pop) begin
               if (w_is_term) begin
                  w_err        = 1'b1;
                  w_err_code   = ERR_BADCHAR;
                  w_state_next = IDLE;
               end
            end else if (w_tmo) begin
               w_err        = 1'b1;
               w_err_code   = ERR_TMO;
               w_state_next = IDLE;
            end
         end
         EXEC: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Line context plus held result/error registers, loaded on entry to EXEC
   // so they change in the same cycle cmd_valid rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_letter      <= '0;
         r_has_digit   <= 1'b0;
         r_cmd_code    <= '0;
         r_cmd_arg     <= '0;
         r_cmd_has_arg <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_err_code    <= '0;
      end else begin
         if (w_latch) begin
            r_letter    <= w_byte;
            r_has_digit <= 1'b0;
         end else if (w_acc_en) begin
            r_has_digit <= 1'b1;
         end
         if (w_state_next == EXEC) begin
            r_cmd_code    <= r_letter;
            r_cmd_arg     <= w_acc_value;
            r_cmd_has_arg <= r_has_digit;
         end
         r_cmd_err <= w_err;
         if (w_err) r_err_code <= w_err_code;
      end
   end

   // Output decode.
   always_comb begin
      fifo_pop    = w_pop;
      cmd_valid   = (r_state == EXEC);
      cmd_code    = r_cmd_code;
      cmd_arg     = r_cmd_arg;
      cmd_has_arg = r_cmd_has_arg;
      cmd_err     = r_cmd_err;
      err_code    = r_err_code;
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: scoreboard bench for uart_cmd_parser. Build with
// CMD_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYC=100).
module tb_uart_cmd_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        fifo_pop;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic [15:0] cmd_arg;
   logic        cmd_has_arg;
   logic        cmd_err;
   logic [1:0]  err_code;

   typedef struct {
      logic        is_err;
      logic [7:0]  code;
      logic [15:0] arg;
      logic        has;
      logic [1:0]  ec;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] byte_q[$];
   logic       gap_en = 1'b0;
   int         n_total = 0;
   int         n_bad   = 0;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .ARG_W       (16),
      .MAX_DIGITS  (5)
`ifdef CMD_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (100)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_pop    (fifo_pop),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_arg     (cmd_arg),
      .cmd_has_arg (cmd_has_arg),
      .cmd_err     (cmd_err),
      .err_code    (err_code)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d @%0t", tag, got, want, $time);
      end
   endtask

   task automatic exp_ok(input logic [7:0] code, input logic [15:0] arg, input logic has);
      exp_t e;
      e.is_err = 1'b0; e.code = code; e.arg = arg; e.has = has; e.ec = 2'd0;
      exp_q.push_back(e);
   endtask

   task automatic exp_err(input logic [1:0] ec);
      exp_t e;
      e.is_err = 1'b1; e.code = 8'h00; e.arg = 16'h0; e.has = 1'b0; e.ec = ec;
      exp_q.push_back(e);
   endtask

   // term: 0 none, 1 CR, 2 LF, 3 CR LF
   task automatic send(input string s, input int term);
      for (int i = 0; i < s.len(); i++) byte_q.push_back(s[i]);
      if (term == 1 || term == 3) byte_q.push_back(8'h0D);
      if (term == 2 || term == 3) byte_q.push_back(8'h0A);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (byte_q.size() == 0 && exp_q.size() == 0) break;
         @(posedge clk);
      end
      check_eq("drain", byte_q.size() + exp_q.size(), 0);
      repeat (5) @(posedge clk);
   endtask

   // Show-ahead FIFO model: the pop seen mid-cycle consumes the head at the edge.
   initial begin
      logic pop_now;
      logic gap;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      forever begin
         @(negedge clk);
         pop_now = fifo_pop;
         @(posedge clk);
         #1;
         if (pop_now && byte_q.size() > 0) void'(byte_q.pop_front());
         gap        = gap_en && ($urandom_range(0, 2) == 0);
         fifo_empty = (byte_q.size() == 0) || gap;
         fifo_data  = gap ? 8'($urandom) : ((byte_q.size() > 0) ? byte_q[0] : 8'h00);
      end
   end

   // Output monitor and scoreboard compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (fifo_empty) check_eq("pop_when_empty", fifo_pop, 0);
         if (cmd_valid) check_eq("pop_in_exec", fifo_pop, 0);
         if (cmd_valid || cmd_err) begin
            check_eq("valid_err_excl", cmd_valid & cmd_err, 0);
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pulse", {cmd_valid, cmd_err}, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("is_err", cmd_err, e.is_err);
               if (e.is_err) begin
                  check_eq("err_code", err_code, e.ec);
               end else begin
                  check_eq("cmd_code", cmd_code, e.code);
                  check_eq("cmd_arg", cmd_arg, e.arg);
                  check_eq("cmd_has_arg", cmd_has_arg, e.has);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      #22;
      check_eq("rst_pop", fifo_pop, 0);
      check_eq("rst_valid", cmd_valid, 0);
      check_eq("rst_err", cmd_err, 0);
      check_eq("rst_code", {cmd_code, cmd_arg, cmd_has_arg, err_code}, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // basic, case fold, CRLF, overflow boundary, bad characters
      exp_ok(8'h53, 16'd123, 1'b1);   send("S123", 1);
      exp_ok(8'h52, 16'd0, 1'b0);     send("r", 3);
      exp_err(2'd1);                  send("X65536", 1);
      exp_ok(8'h58, 16'd65535, 1'b1); send("X65535", 1);
      exp_err(2'd0);                  send("A1#2", 1);
      exp_ok(8'h42, 16'd7, 1'b1);     send("B7", 2);
      exp_err(2'd1);                  send("N000001", 1);
      exp_ok(8'h53, 16'd9, 1'b1);     send("s00009", 1);
      exp_err(2'd0);                  send("#X", 1);
      send("", 3);
      exp_err(2'd1);                  send("X999999", 1);
      exp_err(2'd0);                  send("75", 1);
      exp_ok(8'h5A, 16'd0, 1'b1);     send("z0", 2);
      drain();

      // FIFO gaps
      gap_en = 1'b1;
      exp_ok(8'h43, 16'd42, 1'b1);    send("C42", 1);
      exp_ok(8'h4B, 16'd310, 1'b1);   send("k310", 1);
      drain();
      gap_en = 1'b0;

      // long idle mid-line
`ifdef CMD_TIMEOUT_EN
      exp_err(2'd2);
`else
      exp_ok(8'h44, 16'd4, 1'b1);
`endif
      send("D4", 0);
      repeat (150) @(posedge clk);
      send("", 1);
      drain();

      // reset mid-line
      send("E5", 0);
      for (int i = 0; i < 100 && byte_q.size() > 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      send("QQ", 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_pop", fifo_pop, 0);
      check_eq("mid_rst_valid", cmd_valid, 0);
      check_eq("mid_rst_err", cmd_err, 0);
      check_eq("mid_rst_code", cmd_code, 0);
      check_eq("mid_rst_arg", cmd_arg, 0);
      check_eq("mid_rst_has", cmd_has_arg, 0);
      check_eq("mid_rst_errcode", err_code, 0);
      byte_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_ok(8'h45, 16'd1, 1'b1);     send("E1", 1);
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
